program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Host-side loader that sits directly upstream of the cpu block and drives its external memory ports.
//  Consumes a 32-bit valid/ready command stream and supports four operations:
//    - fill instruction memory;
//    - fill data memory;
//    - dump data memory to an output stream;
//    - start/stop the processor by driving its enable input.
//  The testbench talks only to this block; cpu addr_ext/wen_ext/ren_ext/wdata_ext(_2) come from here.
// PARAMETERS
//  IMEM_AW   9   instruction memory word-address width; addresses wrap modulo 2**IMEM_AW
//  DMEM_AW   10  data memory word-address width; addresses wrap modulo 2**DMEM_AW
//  READ_LAT  1   cycles from dmem_ren high to dmem_rdata valid
// PORTS
//  clk         in   1   single clock, rising edge
//  arst_n      in   1   asynchronous reset, active low
//  s_valid     in   1   command/data word valid
//  s_ready     out  1   loader accepts s_data this cycle
//  s_data      in   32  header or payload word
//  m_valid     out  1   dump word valid
//  m_ready     in   1   consumer accepts m_data
//  m_data      out  32  dumped data-memory word
//  imem_addr   out  32  byte address to cpu addr_ext; equals word index << 2
//  imem_wen    out  1   to cpu wen_ext
//  imem_wdata  out  32  to cpu wdata_ext
//  dmem_addr   out  32  byte address to cpu addr_ext_2
//  dmem_wen    out  1   to cpu wen_ext_2
//  dmem_ren    out  1   to cpu ren_ext_2
//  dmem_wdata  out  32  to cpu wdata_ext_2
//  dmem_rdata  in   32  from cpu rdata_ext_2
//  cpu_enable  out  1   to cpu enable
//  busy        out  1   high in LOAD/DUMP states
//  err         out  1   one-cycle pulse on a rejected header
// BEHAVIOUR
//  Reset: all outputs 0 (s_ready=0 during reset); state IDLE; any partial load or dump is abandoned.
//  Header format: [31:30] op (00 IMEM_LOAD, 01 DMEM_LOAD, 10 DMEM_DUMP, 11 RUN_CTRL);
//    [29:16] base word address; [15:0] count N.
//  Handshake: a word transfers when valid && ready are both high in the same cycle.
//    m_valid/m_data hold stable until m_ready.
//  IDLE: s_ready=1.
//    - Header with N=0 completes at once and the block stays in IDLE.
//    - RUN_CTRL with s_data[0]=1: go to RUN, cpu_enable=1 from the next cycle.
//    - RUN_CTRL with s_data[0]=0 in IDLE: no-op.
//  LOAD: s_ready=1; accepts N payload words.
//    - Word i accepted at cycle t: wen=1, addr={(base+i) mod 2**AW, 2'b00}, wdata=word at t+1.
//    - wen is a single-cycle pulse per word. After word N-1 is accepted, return to IDLE.
//  DUMP: s_ready=0; loops REQ -> WAIT -> OUT for i=0..N-1.
//    - REQ: dmem_ren=1 for one cycle with dmem_addr set.
//    - WAIT: READ_LAT cycles, then dmem_rdata is captured into m_data.
//    - OUT: m_valid=1 until m_ready.
//    - After the last handshake, return to IDLE. One read outstanding at most.
//  RUN: cpu_enable=1, s_ready=1.
//    - RUN_CTRL with [0]=0: cpu_enable=0 next cycle, go to IDLE.
//    - Any other header is dropped, err pulses, and the block stays in RUN (no memory writes while running).
//  Counters: 16-bit remaining count, AW-bit address; address wraps silently at 2**AW-1 -> 0.
//  busy = state in {LOAD, DUMP_REQ, DUMP_WAIT, DUMP_OUT}.
//  imem ren is not driven by this block (cpu ren_ext tied 0 at top level).
//  Simultaneous s_valid with s_ready=0: the word is held by the producer; no loss.
// STRUCTURE
//  loader_pkg: op codes, state encoding, header field bit positions.
//  Sub-module loader_addr_ctr: loadable base/count, increment, wrap at AW, last flag.
//    Instanced once and shared by LOAD and DUMP.
//  Output and pipe registers are reg_arstn-style flops.
// TESTING
//  IMEM_LOAD base=0, N=3 (words A,B,C) -> imem_wen pulses at byte addrs 0,4,8 with A,B,C; busy low after.
//  DMEM_LOAD base=1023, N=2 -> writes at word 1023, then wraps to word 0 (byte addr 0).
//  DMEM_DUMP base=0, N=2 with m_ready low for 3 cycles -> m_data stable while stalled; both words out in order.
//  RUN_CTRL[0]=1 -> cpu_enable=1; IMEM_LOAD then sent -> err pulse, no wen; RUN_CTRL[0]=0 -> cpu_enable=0.
//  arst_n low mid-LOAD after 1 of 4 words -> all outputs 0; next header decoded as new command.
//  Header with N=0 for each op -> no memory access, no m_valid, stays IDLE.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: header layout, op codes, FSM states.
package loader_pkg;

  localparam int DEF_IMEM_AW  = 9;
  localparam int DEF_DMEM_AW  = 10;
  localparam int DEF_READ_LAT = 1;

  localparam int HDR_OP_MSB   = 31;
  localparam int HDR_OP_LSB   = 30;
  localparam int HDR_BASE_LSB = 16;
  localparam int HDR_CNT_MSB  = 15;
  localparam int HDR_CNT_LSB  = 0;

  typedef enum logic [1:0] {
    OP_IMEM_LOAD = 2'b00,
    OP_DMEM_LOAD = 2'b01,
    OP_DMEM_DUMP = 2'b10,
    OP_RUN_CTRL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_DUMP_REQ  = 3'd2,
    ST_DUMP_WAIT = 3'd3,
    ST_DUMP_OUT  = 3'd4,
    ST_RUN       = 3'd5
  } state_e;

endpackage

// File: rtl/loader_addr_ctr.sv
// Word address / remaining-count tracker shared by the LOAD and DUMP sequences.
module loader_addr_ctr
  import loader_pkg::*;
#(
  parameter int AW = DEF_DMEM_AW
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_load,
  input  logic [AW-1:0] i_base,
  input  logic [15:0]   i_count,
  input  logic          i_step,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [AW-1:0] r_addr;
  logic [15:0]   r_rem;

  // The address simply rolls over at 2**AW; callers narrower than AW mask it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_rem  <= i_count;
    end else if (i_step) begin
      r_addr <= r_addr + 1'b1;
      r_rem  <= r_rem - 16'd1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == 16'd1);

endmodule

// File: rtl/program_loader.sv
// Host-side command loader: fills instruction/data memory, dumps data memory,
// and gates the processor enable, all from one 32-bit command stream.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_AW  = DEF_IMEM_AW,
  parameter int DMEM_AW  = DEF_DMEM_AW,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic        dmem_ren,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam int CTR_AW = (DMEM_AW > IMEM_AW) ? DMEM_AW : IMEM_AW;

  // Valid/ready: a word moves on a rising edge where valid and ready are both high;
  // a producer facing ready=0 keeps valid and data steady, and m_valid/m_data hold until m_ready.
  state_e        r_state;
  logic          r_s_ready, r_m_valid, r_imem_wen, r_dmem_wen, r_dmem_ren;
  logic          r_cpu_enable, r_err, r_tgt_dmem;
  logic [31:0]   r_m_data, r_imem_addr, r_imem_wdata, r_dmem_addr, r_dmem_wdata;
  logic [3:0]    r_wait;

  logic          w_acc, w_ctr_load, w_ctr_step, w_ctr_last;
  logic [CTR_AW-1:0] w_ctr_addr;
  logic [15:0]   w_hdr_cnt;
  op_e           w_op;
  logic [31:0]   w_imem_byte, w_dmem_byte;

  assign w_acc       = s_valid && r_s_ready;
  assign w_op        = op_e'(s_data[HDR_OP_MSB:HDR_OP_LSB]);
  assign w_hdr_cnt   = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign w_ctr_load  = (r_state == ST_IDLE) && w_acc;
  assign w_ctr_step  = ((r_state == ST_LOAD) && w_acc) ||
                       ((r_state == ST_DUMP_OUT) && r_m_valid && m_ready);
  assign w_imem_byte = 32'({w_ctr_addr[IMEM_AW-1:0], 2'b00});
  assign w_dmem_byte = 32'({w_ctr_addr[DMEM_AW-1:0], 2'b00});

  loader_addr_ctr #(.AW(CTR_AW)) u_ctr (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_load  (w_ctr_load),
    .i_base  (s_data[HDR_BASE_LSB +: CTR_AW]),
    .i_count (w_hdr_cnt),
    .i_step  (w_ctr_step),
    .o_addr  (w_ctr_addr),
    .o_last  (w_ctr_last)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= ST_IDLE;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_imem_wen   <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_wen   <= 1'b0;
      r_dmem_ren   <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_cpu_enable <= 1'b0;
      r_err        <= 1'b0;
      r_tgt_dmem   <= 1'b0;
      r_wait       <= '0;
    end else begin
      r_imem_wen <= 1'b0;
      r_dmem_wen <= 1'b0;
      r_dmem_ren <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_s_ready <= 1'b1;
          if (w_acc) begin
            if (w_op == OP_RUN_CTRL) begin
              if (s_data[0]) begin
                r_state      <= ST_RUN;
                r_cpu_enable <= 1'b1;
              end
            end else if (w_hdr_cnt != 16'd0) begin
              r_tgt_dmem <= (w_op == OP_DMEM_LOAD);
              if (w_op == OP_DMEM_DUMP) begin
                r_state   <= ST_DUMP_REQ;
                r_s_ready <= 1'b0;
              end else begin
                r_state <= ST_LOAD;
              end
            end
          end
        end
        ST_LOAD: begin
          if (w_acc) begin
            if (r_tgt_dmem) begin
              r_dmem_wen   <= 1'b1;
              r_dmem_addr  <= w_dmem_byte;
              r_dmem_wdata <= s_data;
            end else begin
              r_imem_wen   <= 1'b1;
              r_imem_addr  <= w_imem_byte;
              r_imem_wdata <= s_data;
            end
            if (w_ctr_last) r_state <= ST_IDLE;
          end
        end
        ST_DUMP_REQ: begin
          r_dmem_ren  <= 1'b1;
          r_dmem_addr <= w_dmem_byte;
          r_wait      <= '0;
          r_state     <= ST_DUMP_WAIT;
        end
        // ren is visible during wait count 0, so read data lands at count READ_LAT.
        ST_DUMP_WAIT: begin
          if (r_wait == 4'(READ_LAT)) begin
            r_m_data  <= dmem_rdata;
            r_m_valid <= 1'b1;
            r_state   <= ST_DUMP_OUT;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        ST_DUMP_OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            if (w_ctr_last) begin
              r_state   <= ST_IDLE;
              r_s_ready <= 1'b1;
            end else begin
              r_state <= ST_DUMP_REQ;
            end
          end
        end
        ST_RUN: begin
          if (w_acc) begin
            if (w_op == OP_RUN_CTRL && !s_data[0]) begin
              r_cpu_enable <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign imem_addr  = r_imem_addr;
  assign imem_wen   = r_imem_wen;
  assign imem_wdata = r_imem_wdata;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wen   = r_dmem_wen;
  assign dmem_ren   = r_dmem_ren;
  assign dmem_wdata = r_dmem_wdata;
  assign cpu_enable = r_cpu_enable;
  assign err        = r_err;
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_DUMP_REQ) ||
                      (r_state == ST_DUMP_WAIT) || (r_state == ST_DUMP_OUT);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random command traffic against a memory-level reference model.
module tb_program_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n  = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data  = '0;
  logic        m_ready = 1'b0;
  logic [31:0] dmem_rdata;
  logic        s_ready, m_valid, imem_wen, dmem_wen, dmem_ren, cpu_enable, busy, err;
  logic [31:0] m_data, imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic [2:0]  dbg_state;

  program_loader dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_wdata (imem_wdata),
    .dmem_addr  (dmem_addr),
    .dmem_wen   (dmem_wen),
    .dmem_ren   (dmem_ren),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];       // {is_dmem, byte_addr, data}
  logic [31:0] exp_dump_q[$];
  logic [64:0] obs_wr[$];
  logic [31:0] obs_dump[$];
  int wr_rd = 0;
  int dp_rd = 0;
  logic [31:0] ref_mem [1024];
  int err_exp = 0;
  int err_seen = 0;
  int hold_checks = 0;
  int hold_viol = 0;
  int stall_req = 0;
  int stall_ack = 0;
  int stall_cnt = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  function automatic logic [31:0] init_val(input int a);
    return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] op, input int base, input int n);
    return {op, base[13:0], n[15:0]};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- cpu-side data memory model ----------------
  logic [31:0] phys [1024];
  bit          written [1024];
  always @(posedge clk) begin
    if (dmem_wen) begin
      phys[dmem_addr[11:2]]    <= dmem_wdata;
      written[dmem_addr[11:2]] <= 1'b1;
    end
    if (dmem_ren)
      dmem_rdata <= written[dmem_addr[11:2]] ? phys[dmem_addr[11:2]] : init_val(int'(dmem_addr[11:2]));
  end

  // ---------------- output monitor and consumer ----------------
  always @(negedge clk) begin
    if (!arst_n) begin
      prev_hold = 1'b0;
      m_ready   = 1'b0;
    end else begin
      if (imem_wen) obs_wr.push_back({1'b0, imem_addr, imem_wdata});
      if (dmem_wen) obs_wr.push_back({1'b1, dmem_addr, dmem_wdata});
      if (err) err_seen++;
      if (prev_hold) begin
        hold_checks++;
        if (!(m_valid && m_data == prev_data)) hold_viol++;
      end
      if (stall_req != stall_ack && m_valid) begin
        stall_cnt = 3;
        stall_ack = stall_req;
      end
      if (stall_cnt > 0) begin
        m_ready = 1'b0;
        stall_cnt--;
      end else begin
        m_ready = ($urandom_range(0, 3) != 0);
      end
      if (m_valid && m_ready) obs_dump.push_back(m_data);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] w);
    int t;
    s_valid = 1'b1;
    s_data  = w;
    t = 0;
    while (!s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("s_ready_timeout", 65'(t < 500), 65'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic cmd_load(input bit dmem, input int base, input int n);
    logic [31:0] d;
    int wa;
    send(hdr(dmem ? 2'b01 : 2'b00, base, n));
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if (dmem) begin
        wa = (base + i) % 1024;
        ref_mem[wa] = d;
      end else begin
        wa = (base + i) % 512;
      end
      exp_q.push_back({dmem, 32'(wa * 4), d});
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(d);
    end
  endtask

  task automatic cmd_dump(input int base, input int n);
    for (int i = 0; i < n; i++) exp_dump_q.push_back(ref_mem[(base + i) % 1024]);
    stall_req++;
    send(hdr(2'b10, base, n));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || (obs_wr.size() - wr_rd) < exp_q.size() ||
            (obs_dump.size() - dp_rd) < exp_dump_q.size()) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) $display("note: stuck, dbg_state=%0d", dbg_state);
    check("idle_timeout", 65'(t < 3000), 65'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    check("wr_count", 65'(obs_wr.size() - wr_rd), 65'(exp_q.size()));
    while (wr_rd < obs_wr.size() && exp_q.size() > 0) begin
      check("mem_write", obs_wr[wr_rd], exp_q.pop_front());
      wr_rd++;
    end
    wr_rd = obs_wr.size();
    exp_q = {};
    check("dump_count", 65'(obs_dump.size() - dp_rd), 65'(exp_dump_q.size()));
    while (dp_rd < obs_dump.size() && exp_dump_q.size() > 0) begin
      check("dump_word", 65'(obs_dump[dp_rd]), 65'(exp_dump_q.pop_front()));
      dp_rd++;
    end
    dp_rd = obs_dump.size();
    exp_dump_q = {};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},   65'(s_ready), 65'd0);
    check({tag, "_m_valid"},   65'(m_valid), 65'd0);
    check({tag, "_m_data"},    65'(m_data), 65'd0);
    check({tag, "_imem_addr"}, 65'(imem_addr), 65'd0);
    check({tag, "_imem_wen"},  65'(imem_wen), 65'd0);
    check({tag, "_imem_wdat"}, 65'(imem_wdata), 65'd0);
    check({tag, "_dmem_addr"}, 65'(dmem_addr), 65'd0);
    check({tag, "_dmem_wen"},  65'(dmem_wen), 65'd0);
    check({tag, "_dmem_ren"},  65'(dmem_ren), 65'd0);
    check({tag, "_dmem_wdat"}, 65'(dmem_wdata), 65'd0);
    check({tag, "_cpu_en"},    65'(cpu_enable), 65'd0);
    check({tag, "_busy"},      65'(busy), 65'd0);
    check({tag, "_err"},       65'(err), 65'd0);
  endtask

  task automatic run_session(input logic [31:0] bad_hdr);
    send(hdr(2'b11, 0, 1));
    check("run_cpu_en_on", 65'(cpu_enable), 65'd1);
    err_exp++;
    send(bad_hdr);
    repeat (2) @(negedge clk);
    check("run_busy", 65'(busy), 65'd0);
    check("run_cpu_en_hold", 65'(cpu_enable), 65'd1);
    check("run_err_count", 65'(err_seen), 65'(err_exp));
    send(hdr(2'b11, 0, 0));
    check("run_cpu_en_off", 65'(cpu_enable), 65'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int op, n, base;
    logic [31:0] d;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_s_ready", 65'(s_ready), 65'd1);

    // imem fill at base 0
    cmd_load(1'b0, 0, 3);
    wait_idle();
    drain();
    check("imem_busy_after", 65'(busy), 65'd0);

    // dmem fill wrapping from the top word to word 0
    cmd_load(1'b1, 1023, 2);
    wait_idle();
    drain();

    // dump with stalled consumer; next header must be held off until the dump ends
    cmd_dump(0, 2);
    cmd_load(1'b0, 100, 1);
    wait_idle();
    drain();
    check("hold_exercised", 65'(hold_checks > 0), 65'd1);
    check("hold_stable", 65'(hold_viol), 65'd0);

    // processor enable and rejected header while running
    run_session(hdr(2'b00, 0, 2));
    wait_idle();
    drain();

    // zero-length headers for every op
    for (int k = 0; k < 4; k++) begin
      send(hdr(k[1:0], $urandom_range(0, 16383), 0));
      repeat (3) @(negedge clk);
      check("n0_busy", 65'(busy), 65'd0);
      check("n0_s_ready", 65'(s_ready), 65'd1);
      check("n0_m_valid", 65'(m_valid), 65'd0);
      check("n0_cpu_en", 65'(cpu_enable), 65'd0);
    end
    wait_idle();
    drain();

    // reset in the middle of a four-word load
    send(hdr(2'b00, 20, 4));
    d = $urandom;
    exp_q.push_back({1'b0, 32'(20 * 4), d});
    send(d);
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    arst_n = 1'b1;
    @(negedge clk);
    cmd_load(1'b0, 7, 2);
    wait_idle();
    drain();

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      op   = $urandom_range(0, 3);
      n    = $urandom_range(0, 5);
      base = $urandom_range(0, 16383);
      case (op)
        0: cmd_load(1'b0, base, n);
        1: cmd_load(1'b1, base, n);
        2: cmd_dump(base, n);
        default: begin
          op = $urandom_range(0, 3);
          if (op == 3) n = n | 1;
          run_session(hdr(op[1:0], base, n));
        end
      endcase
      wait_idle();
      drain();
    end

    repeat (5) @(negedge clk);
    drain();
    check("final_err_count", 65'(err_seen), 65'(err_exp));
    check("final_hold", 65'(hold_viol), 65'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
